// File: rtl/a51_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : a51_phase_sequencer
//  Description : Phase sequencer for an A5/1 keystream generator. Steps
//                through key load, frame load, majority mixing and keystream
//                output, and provides a per-phase bit index and one-hot phase
//                flags for the three LFSRs. It can also auto-advance the
//                frame number to run back-to-back bursts.
//  Revision    : 1.0  initial release
// ============================================================================
module a51_phase_sequencer #(
  parameter int KEY_LEN   = 64,
  parameter int FRAME_LEN = 22,
  parameter int MIX_LEN   = 100,
  parameter int OUT_LEN   = 228,
  parameter int CW        = 10,
  parameter int FRAME_W   = 22
) (
  input  logic               C,
  input  logic               CLR,
  input  logic               START,
  input  logic               ABORT,
  input  logic               ENABLE,
  input  logic               AUTO_NEXT,
  input  logic [FRAME_W-1:0] FRAME_IN,
  output logic [CW-1:0]      Q,
  output logic [FRAME_W-1:0] FRAME_OUT,
  output logic               STAGEONE,
  output logic               STAGETWO,
  output logic               STAGETHREE,
  output logic               OUTPUTSTAGE,
  output logic               STAGE_FIRST,
  output logic               FRAME_DONE,
  output logic               DONE,
  output logic               BUSY
);

  // Explicit 3-bit state encoding; codes 6 and 7 are unreachable and recover to IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEY    = 3'd1,
    S_FRAME  = 3'd2,
    S_MIX    = 3'd3,
    S_OUT    = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  // Last index value of each phase.
  localparam logic [CW-1:0] c_KEY_LAST   = CW'(KEY_LEN - 1);
  localparam logic [CW-1:0] c_FRAME_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] c_MIX_LAST   = CW'(MIX_LEN - 1);
  localparam logic [CW-1:0] c_OUT_LAST   = CW'(OUT_LEN - 1);

  // Registered state and outputs.
  state_t               r_state;
  logic [CW-1:0]        r_q;
  logic [FRAME_W-1:0]   r_frame;
  logic                 r_stage1;
  logic                 r_stage2;
  logic                 r_stage3;
  logic                 r_stage4;
  logic                 r_first;
  logic                 r_frame_done;
  logic                 r_done;
  logic                 r_busy;

  // Next-state values.
  state_t               w_state_nxt;
  logic [CW-1:0]        w_q_nxt;
  logic [FRAME_W-1:0]   w_frame_nxt;
  logic                 w_frame_done_nxt;
  logic                 w_done_nxt;
  logic                 w_active_nxt;

  // Helpers for the current phase.
  logic [CW-1:0]        w_last;
  logic                 w_phase_end;

  // Select the terminal index of whichever phase is currently running.
  always_comb begin
    w_last = '0;
    case (r_state)
      S_KEY:   w_last = c_KEY_LAST;
      S_FRAME: w_last = c_FRAME_LAST;
      S_MIX:   w_last = c_MIX_LAST;
      S_OUT:   w_last = c_OUT_LAST;
      default: w_last = '0;
    endcase
  end

  assign w_phase_end = (r_q == w_last);

  // Next-state logic: abort beats start/enable; idle/finish wait for start,
  // active phases advance only on enabled cycles.
  always_comb begin
    w_state_nxt      = r_state;
    w_q_nxt          = r_q;
    w_frame_nxt      = r_frame;
    w_done_nxt       = r_done;
    w_frame_done_nxt = 1'b0;

    if (ABORT) begin
      // Frame number survives an abort so software can inspect it.
      w_state_nxt = S_IDLE;
      w_q_nxt     = '0;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FINISH: begin
          // Start is accepted regardless of ENABLE.
          if (START) begin
            w_state_nxt = S_KEY;
            w_q_nxt     = '0;
            w_frame_nxt = FRAME_IN;
            w_done_nxt  = 1'b0;
          end
        end

        S_KEY, S_FRAME, S_MIX, S_OUT: begin
          if (ENABLE) begin
            if (!w_phase_end) begin
              w_q_nxt = r_q + 1'b1;
            end else begin
              w_q_nxt = '0;
              case (r_state)
                S_KEY:   w_state_nxt = S_FRAME;
                S_FRAME: w_state_nxt = S_MIX;
                S_MIX:   w_state_nxt = S_OUT;
                default: begin
                  // End of keystream burst: either chain the next frame or stop.
                  w_frame_done_nxt = 1'b1;
                  if (AUTO_NEXT) begin
                    w_frame_nxt = r_frame + 1'b1;
                    w_state_nxt = S_KEY;
                  end else begin
                    w_state_nxt = S_FINISH;
                    w_done_nxt  = 1'b1;
                  end
                end
              endcase
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_q_nxt     = '0;
          w_done_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign w_active_nxt = (w_state_nxt == S_KEY)   || (w_state_nxt == S_FRAME) ||
                        (w_state_nxt == S_MIX)   || (w_state_nxt == S_OUT);

  // State, index, frame and decoded flags all register together so every output is glitch-free.
  always_ff @(posedge C) begin
    if (CLR) begin
      r_state      <= S_IDLE;
      r_q          <= '0;
      r_frame      <= '0;
      r_stage1     <= 1'b0;
      r_stage2     <= 1'b0;
      r_stage3     <= 1'b0;
      r_stage4     <= 1'b0;
      r_first      <= 1'b0;
      r_frame_done <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_q          <= w_q_nxt;
      r_frame      <= w_frame_nxt;
      r_stage1     <= (w_state_nxt == S_KEY);
      r_stage2     <= (w_state_nxt == S_FRAME);
      r_stage3     <= (w_state_nxt == S_MIX);
      r_stage4     <= (w_state_nxt == S_OUT);
      r_first      <= w_active_nxt && (w_q_nxt == '0);
      r_frame_done <= w_frame_done_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= w_active_nxt;
    end
  end

  assign Q           = r_q;
  assign FRAME_OUT   = r_frame;
  assign STAGEONE    = r_stage1;
  assign STAGETWO    = r_stage2;
  assign STAGETHREE  = r_stage3;
  assign OUTPUTSTAGE = r_stage4;
  assign STAGE_FIRST = r_first;
  assign FRAME_DONE  = r_frame_done;
  assign DONE        = r_done;
  assign BUSY        = r_busy;

endmodule
`default_nettype wire
